div_recon_checker: RTL and testbench
====================================

# div_recon_checker

Sequential error-measurement block for our 16/8 array dividers, exact and approximate. It takes one division sample (n, d, q, r) and rebuilds the dividend as recon = q*d + r with an 8-iteration shift-add multiplier. It reports the absolute error |n - recon| and a remainder-validity flag, and keeps running totals for mean-absolute-error characterisation. It sits in the characterisation harness downstream of any divider_array_* instance.

## Interface
Parameters:
- N_W, 16, dividend and reconstruction width
- D_W, 8, divisor, quotient and remainder width
- SUM_W, 32, error-sum accumulator width
- CNT_W, 16, sample-counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- n  in  N_W  golden dividend
- d  in  D_W  divisor
- q  in  D_W  quotient under test
- r  in  D_W  remainder under test
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- recon  out  N_W  q*d + r
- err_abs  out  N_W  |n - recon|
- rem_bad  out  1  r >= d, with d != 0
- clr_stats  in  1  synchronous clear of err_sum and sample_cnt
- err_sum  out  SUM_W  saturating sum of err_abs
- sample_cnt  out  CNT_W  saturating count of completed samples

## Operation
FSM states are IDLE, MUL, FIN and HOLD.
- **IDLE**: in_ready=1. On in_valid&&in_ready:
  - latch n, d, q, r;
  - clear the accumulator acc (N_W bits) and the bit index i;
  - go to MUL.
- **MUL**: one step per cycle, for i = 0..7:
  - if q_l[i]=1, acc += d_l << i;
  - after i=7, go to FIN.
  - acc never exceeds 255*255 = 65025, so no overflow is possible.
- **FIN**, one cycle:
  - recon <= acc + r_l. The maximum is 65280, so it fits in N_W.
  - err_abs <= (n_l >= recon) ? n_l - recon : recon - n_l.
  - rem_bad <= (d_l != 0) && (r_l >= d_l).
  - err_sum += err_abs, saturating at 2^SUM_W-1.
  - sample_cnt += 1, saturating at 2^CNT_W-1.
  - Go to HOLD.
- **HOLD**: out_valid=1. On out_ready, go to IDLE.
  - in_ready=0 in every state except IDLE. There is no overlap of samples.
- **d=0**: acc stays 0, recon=r, rem_bad=0. This is not an error condition.
- **clr_stats**:
  - Outside FIN, it zeroes err_sum and sample_cnt on the next edge.
  - In the same cycle as FIN, the clear applies first, so the new sample is counted: err_sum=err_abs, sample_cnt=1.
- **rst**: asynchronous; forces IDLE from any state. All of the following go to 0: out_valid, recon, err_abs, rem_bad, err_sum, sample_cnt and all internal registers. in_ready is 1 after reset.

## Timing
- A sample is accepted at edge T.
- The MUL steps occur at edges T+1..T+8.
- FIN runs at edge T+9. out_valid is high from T+9 until the edge where out_ready=1 is sampled.
- Minimum throughput is one sample per 11 cycles (out_ready tied high: accept T, output T+9, IDLE T+10, next accept T+11).
- recon, err_abs, rem_bad, err_sum and sample_cnt are registered. They are stable throughout HOLD and keep their values after returning to IDLE until the next FIN.
- out_ready is ignored when out_valid=0. in_valid is ignored when in_ready=0. Inputs need only be stable at the accept edge.

## Structure
- Shared package div_chk_pkg holds:
  - N_W, D_W, SUM_W and CNT_W defaults;
  - the state enum {IDLE, MUL, FIN, HOLD};
  - a saturating-add helper function.
- Sub-module shift_add_mul8 holds the acc/i datapath, with controls start and step and outputs acc and done.
- The top level holds the FSM, the FIN arithmetic and the statistics registers.

## Test plan
- n=1000, d=7, q=142, r=6, out_ready=1:
  - out_valid rises at T+9;
  - recon=1000, err_abs=0, rem_bad=0, sample_cnt=1.
- Next sample n=1000, d=7, q=140, r=6: recon=986, err_abs=14, err_sum=14, sample_cnt=2. Then n=500, d=10, q=52, r=3: recon=523, err_abs=23, err_sum=37.
- n=300, d=0, q=255, r=5: recon=5, err_abs=295, rem_bad=0. Then n=65535, d=255, q=255, r=255: recon=65280, err_abs=255, rem_bad=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD.
  - out_valid and recon stay stable, in_ready=0, a second in_valid is not accepted.
  - After out_ready=1, in_ready=1 on the next cycle.
- clr_stats:
  - asserted in IDLE: err_sum=0 and sample_cnt=0 next cycle;
  - asserted in the FIN cycle of sample err_abs=14: err_sum=14, sample_cnt=1.
- Assert rst asynchronously mid-MUL (edge T+4):
  - all outputs are 0 immediately and in_ready=1;
  - a fresh sample afterwards completes normally in 9 cycles.

Source files
------------

// File: rtl/div_chk_pkg.sv
// ---------------------------------------------------------------------------
// div_chk_pkg : shared widths, FSM states and saturating add   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_chk_pkg;

  localparam int N_W_DEF   = 16;
  localparam int D_W_DEF   = 8;
  localparam int SUM_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Adds in 65 bits so the carry is visible, then clamps to the w-bit maximum.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_mul8.sv
// ---------------------------------------------------------------------------
// shift_add_mul8 : one-bit-per-cycle shift-add multiplier q*d   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_add_mul8 #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  input  logic [D_W-1:0] d,
  input  logic [D_W-1:0] q,
  output logic [N_W-1:0] acc,
  output logic           done
);

  localparam int I_W = $clog2(D_W);

  logic [N_W-1:0] acc_q, acc_d;
  logic [I_W-1:0] i_q, i_d;

  always_comb begin
    acc_d = acc_q;
    i_d   = i_q;
    if (start) begin
      acc_d = '0;
      i_d   = '0;
    end else if (step) begin
      if (q[i_q]) begin
        acc_d = acc_q + (N_W'(d) << i_q);
      end
      i_d = i_q + I_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      i_q   <= '0;
    end else begin
      acc_q <= acc_d;
      i_q   <= i_d;
    end
  end

  assign acc  = acc_q;
  // High during the step that consumes the top quotient bit.
  assign done = step && (i_q == I_W'(D_W - 1));

endmodule

`default_nettype wire

// File: rtl/div_recon_checker.sv
// ---------------------------------------------------------------------------
// div_recon_checker : rebuilds q*d+r, reports |n-recon| and error stats  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_recon_checker
  import div_chk_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int D_W   = D_W_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   n,
  input  logic [D_W-1:0]   d,
  input  logic [D_W-1:0]   q,
  input  logic [D_W-1:0]   r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   recon,
  output logic [N_W-1:0]   err_abs,
  output logic             rem_bad,
  input  logic             clr_stats,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] sample_cnt
);

  state_e state_q, state_d;

  logic [N_W-1:0]   n_q;
  logic [D_W-1:0]   d_q, q_q, r_q;
  logic [N_W-1:0]   recon_q, recon_d;
  logic [N_W-1:0]   err_abs_q, err_abs_d;
  logic             rem_bad_q, rem_bad_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d, sum_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  logic             accept;
  logic             mul_step;
  logic             mul_done;
  logic [N_W-1:0]   acc;

  assign accept   = in_valid && (state_q == IDLE);
  assign mul_step = (state_q == MUL);

  shift_add_mul8 #(
    .N_W (N_W),
    .D_W (D_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .step  (mul_step),
    .d     (d_q),
    .q     (q_q),
    .acc   (acc),
    .done  (mul_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = MUL;
      MUL:     if (mul_done)  state_d = FIN;
      FIN:                    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    recon_d   = acc + N_W'(r_q);
    err_abs_d = (n_q >= recon_d) ? (n_q - recon_d) : (recon_d - n_q);
    rem_bad_d = (d_q != '0) && (r_q >= d_q);
  end

  // A clear coinciding with FIN is applied before the new sample is added.
  always_comb begin
    sum_base  = clr_stats ? '0 : err_sum_q;
    cnt_base  = clr_stats ? '0 : cnt_q;
    err_sum_d = sum_base;
    cnt_d     = cnt_base;
    if (state_q == FIN) begin
      err_sum_d = SUM_W'(sat_add(64'(sum_base), 64'(err_abs_d), SUM_W));
      cnt_d     = CNT_W'(sat_add(64'(cnt_base), 64'd1, CNT_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      recon_q   <= '0;
      err_abs_q <= '0;
      rem_bad_q <= 1'b0;
      err_sum_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_sum_q <= err_sum_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        n_q <= n;
        d_q <= d;
        q_q <= q;
        r_q <= r;
      end
      if (state_q == FIN) begin
        recon_q   <= recon_d;
        err_abs_q <= err_abs_d;
        rem_bad_q <= rem_bad_d;
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign recon      = recon_q;
  assign err_abs    = err_abs_q;
  assign rem_bad    = rem_bad_q;
  assign err_sum    = err_sum_q;
  assign sample_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_div_recon_checker.sv
// ---------------------------------------------------------------------------
// tb_div_recon_checker : directed vectors with hand-computed results  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_recon_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] recon;
  logic [15:0] err_abs;
  logic        rem_bad;
  logic        clr_stats;
  logic [31:0] err_sum;
  logic [15:0] sample_cnt;

  int vectors;
  int miscompares;

  div_recon_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n          (n),
    .d          (d),
    .q          (q),
    .r          (r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .recon      (recon),
    .err_abs    (err_abs),
    .rem_bad    (rem_bad),
    .clr_stats  (clr_stats),
    .err_sum    (err_sum),
    .sample_cnt (sample_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one sample, checks the 9-edge latency, and returns inside HOLD.
  task automatic send(input logic [15:0] vn, input logic [7:0] vd,
                      input logic [7:0] vq, input logic [7:0] vr,
                      input logic clr_fin);
    n = vn; d = vd; q = vq; r = vr;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("busy_after_accept", in_ready, 0);
    repeat (8) tick;
    chk("no_valid_at_T8", out_valid, 0);
    clr_stats = clr_fin;
    tick;
    clr_stats = 1'b0;
    chk("valid_at_T9", out_valid, 1);
  endtask

  task automatic check_res(input logic [15:0] er, input logic [15:0] ee,
                           input logic eb, input logic [31:0] es,
                           input logic [15:0] ec);
    chk("recon", recon, er);
    chk("err_abs", err_abs, ee);
    chk("rem_bad", rem_bad, eb);
    chk("err_sum", err_sum, es);
    chk("sample_cnt", sample_cnt, ec);
  endtask

  task automatic release_hold;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("ready_after_release", in_ready, 1);
    chk("valid_after_release", out_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    clr_stats   = 1'b0;
    n = '0; d = '0; q = '0; r = '0;
    #12 rst = 1'b0;
    tick;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    check_res(16'd0, 16'd0, 1'b0, 32'd0, 16'd0);

    send(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0);
    check_res(16'd1000, 16'd0, 1'b0, 32'd0, 16'd1);
    release_hold;

    send(16'd1000, 8'd7, 8'd140, 8'd6, 1'b0);
    check_res(16'd986, 16'd14, 1'b0, 32'd14, 16'd2);
    release_hold;

    send(16'd500, 8'd10, 8'd52, 8'd3, 1'b0);
    check_res(16'd523, 16'd23, 1'b0, 32'd37, 16'd3);
    release_hold;

    send(16'd300, 8'd0, 8'd255, 8'd5, 1'b0);
    check_res(16'd5, 16'd295, 1'b0, 32'd332, 16'd4);
    release_hold;

    send(16'd65535, 8'd255, 8'd255, 8'd255, 1'b0);
    check_res(16'd65280, 16'd255, 1'b1, 32'd587, 16'd5);

    // Backpressure with a competing sample offered during HOLD.
    n = 16'd1; d = 8'd1; q = 8'd1; r = 8'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_recon", recon, 16'd65280);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_hold;
    chk("idle_recon_kept", recon, 16'd65280);
    chk("idle_cnt_kept", sample_cnt, 16'd5);

    clr_stats = 1'b1;
    tick;
    clr_stats = 1'b0;
    chk("clr_idle_sum", err_sum, 0);
    chk("clr_idle_cnt", sample_cnt, 0);

    send(16'd500, 8'd10, 8'd52, 8'd3, 1'b0);
    check_res(16'd523, 16'd23, 1'b0, 32'd23, 16'd1);
    release_hold;

    send(16'd1000, 8'd7, 8'd140, 8'd6, 1'b1);
    check_res(16'd986, 16'd14, 1'b0, 32'd14, 16'd1);
    release_hold;

    // Asynchronous reset in the middle of the multiply.
    n = 16'd1000; d = 8'd7; q = 8'd142; r = 8'd6;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    check_res(16'd0, 16'd0, 1'b0, 32'd0, 16'd0);
    #2 rst = 1'b0;
    tick;
    chk("post_rst_idle", in_ready, 1);

    send(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0);
    check_res(16'd1000, 16'd0, 1'b0, 32'd0, 16'd1);
    release_hold;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
